// File: rtl/pipe_pkg.sv
// Shared pipeline types: write-back select encodings, skid-buffer states and
// the default-width EX/MEM entry layout.
package pipe_pkg;

    typedef enum logic [1:0] {
        WDSEL_ALU = 2'd0,
        WDSEL_MEM = 2'd1,
        WDSEL_PC4 = 2'd2
    } wdsel_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    localparam int unsigned PIPE_XLEN = 32;
    localparam int unsigned PIPE_RFAW = 5;

    typedef struct packed {
        logic [PIPE_XLEN-1:0] alu_c;
        logic [PIPE_XLEN-1:0] rs2;
        logic [PIPE_XLEN-1:0] pc;
        logic [PIPE_RFAW-1:0] rd;
        logic                 reg_write;
        logic                 mem_read;
        logic                 mem_write;
        wdsel_e               wdsel;
`ifdef EXMEM_BRANCH_RESOLVE_EN
        logic                 taken;
        logic [PIPE_XLEN-1:0] target;
`endif
    } ex_mem_entry_t;

    // Writes to x0 are architecturally dead, so they never request write-back.
    function automatic logic gated_reg_write(input logic reg_write, input logic rd_nonzero);
        return reg_write && rd_nonzero;
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Generic two-entry (head + skid) valid/ready buffer with a registered in_ready
// and a synchronous flush that empties it at the next edge.
module skid_buf2
    import pipe_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_e   state_q, state_d;
    logic         in_ready_q, in_ready_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] skid_q, skid_d;
    logic         head_valid;
    logic         in_fire, out_fire;

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = head_valid && out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= BUF_EMPTY;
            in_ready_q <= 1'b1;
            head_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = BUF_EMPTY;
        end else begin
            case (state_q)
                BUF_EMPTY: if (in_fire) state_d = BUF_ONE;
                BUF_ONE: begin
                    if (in_fire && !out_fire)      state_d = BUF_FULL;
                    else if (!in_fire && out_fire) state_d = BUF_EMPTY;
                end
                BUF_FULL:  if (out_fire) state_d = BUF_ONE;
                default:   state_d = BUF_EMPTY;
            endcase
        end
    end

    // Data only moves on a capture or a skid-to-head shift; flush leaves it untouched.
    always_comb begin
        head_d     = head_q;
        skid_d     = skid_q;
        in_ready_d = (state_d != BUF_FULL);
        if (!flush) begin
            case (state_q)
                BUF_EMPTY: if (in_fire) head_d = in_data;
                BUF_ONE: begin
                    if (in_fire && out_fire) head_d = in_data;
                    else if (in_fire)        skid_d = in_data;
                end
                BUF_FULL:  if (out_fire) head_d = skid_q;
                default:   ;
            endcase
        end
    end

    always_comb begin
        head_valid = (state_q != BUF_EMPTY);
        out_valid  = head_valid;
        in_ready   = in_ready_q;
        out_data   = head_q;
    end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register built on a two-entry skid buffer, with forwarding of
// the head entry. Optional branch resolution outputs under EXMEM_BRANCH_RESOLVE_EN.
module ex_mem_reg
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RFAW = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_alu_c,
    input  logic            in_zero,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_pc,
    input  logic [RFAW-1:0] in_rd,
    input  logic            in_reg_write,
    input  logic            in_mem_read,
    input  logic            in_mem_write,
    input  logic            in_is_branch,
    input  logic [1:0]      in_wdsel,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_alu_c,
    output logic [XLEN-1:0] out_rs2,
    output logic [XLEN-1:0] out_pc,
    output logic [RFAW-1:0] out_rd,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic [1:0]      out_wdsel,
    output logic            fwd_valid,
    output logic [RFAW-1:0] fwd_rd,
    output logic [XLEN-1:0] fwd_data
`ifdef EXMEM_BRANCH_RESOLVE_EN
    ,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_target
`endif
);

    // Same layout as ex_mem_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [XLEN-1:0] alu_c;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] pc;
        logic [RFAW-1:0] rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        wdsel_e          wdsel;
`ifdef EXMEM_BRANCH_RESOLVE_EN
        logic            taken;
        logic [XLEN-1:0] target;
`endif
    } entry_t;

    entry_t in_entry;
    entry_t head;

    always_comb begin
        in_entry           = '0;
        in_entry.alu_c     = in_alu_c;
        in_entry.rs2       = in_rs2;
        in_entry.pc        = in_pc;
        in_entry.rd        = in_rd;
        in_entry.reg_write = gated_reg_write(in_reg_write, in_rd != '0);
        in_entry.mem_read  = in_mem_read;
        in_entry.mem_write = in_mem_write;
        in_entry.wdsel     = wdsel_e'(in_wdsel);
`ifdef EXMEM_BRANCH_RESOLVE_EN
        in_entry.taken     = in_is_branch && in_zero;
        in_entry.target    = {in_alu_c[XLEN-1:1], 1'b0};
`endif
    end

    skid_buf2 #(
        .W ($bits(entry_t))
    ) u_buf (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    always_comb begin
        out_alu_c     = head.alu_c;
        out_rs2       = head.rs2;
        out_pc        = head.pc;
        out_rd        = head.rd;
        out_reg_write = head.reg_write;
        out_mem_read  = head.mem_read;
        out_mem_write = head.mem_write;
        out_wdsel     = head.wdsel;
        fwd_valid     = out_valid && head.reg_write && (head.rd != '0);
        fwd_rd        = head.rd;
        fwd_data      = head.alu_c;
`ifdef EXMEM_BRANCH_RESOLVE_EN
        branch_taken  = out_valid && head.taken;
        branch_target = head.target;
`endif
    end

`ifndef EXMEM_BRANCH_RESOLVE_EN
    logic unused_branch_inputs;
    assign unused_branch_inputs = in_zero ^ in_is_branch;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Randomized and directed bench for ex_mem_reg against a queue-based reference model.
module tb_ex_mem_reg;

    typedef struct packed {
        logic [31:0] alu_c;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [1:0]  wdsel;
        logic        zero;
        logic        br;
    } tb_ent_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    tb_ent_t     cur = '0;

    logic        in_ready, out_valid;
    logic [31:0] out_alu_c, out_rs2, out_pc, fwd_data;
    logic [4:0]  out_rd, fwd_rd;
    logic        out_reg_write, out_mem_read, out_mem_write, fwd_valid;
    logic [1:0]  out_wdsel;
`ifdef EXMEM_BRANCH_RESOLVE_EN
    logic        branch_taken;
    logic [31:0] branch_target;
`endif

    always #5 clk = ~clk;

    ex_mem_reg #(.XLEN(32), .RFAW(5)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_alu_c      (cur.alu_c),
        .in_zero       (cur.zero),
        .in_rs2        (cur.rs2),
        .in_pc         (cur.pc),
        .in_rd         (cur.rd),
        .in_reg_write  (cur.rw),
        .in_mem_read   (cur.mr),
        .in_mem_write  (cur.mw),
        .in_is_branch  (cur.br),
        .in_wdsel      (cur.wdsel),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_alu_c     (out_alu_c),
        .out_rs2       (out_rs2),
        .out_pc        (out_pc),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write),
        .out_mem_read  (out_mem_read),
        .out_mem_write (out_mem_write),
        .out_wdsel     (out_wdsel),
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data)
`ifdef EXMEM_BRANCH_RESOLVE_EN
        ,
        .branch_taken  (branch_taken),
        .branch_target (branch_target)
`endif
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: an in-order queue of at most two entries plus the last head seen.
    tb_ent_t     q[$];
    tb_ent_t     last = '0;
    logic        last_in_acc = 1'b0;
    logic [31:0] seen[$];

    function automatic tb_ent_t captured(input tb_ent_t e);
        tb_ent_t r = e;
        r.rw = e.rw && (e.rd != 5'd0);
        return r;
    endfunction

    function automatic tb_ent_t rand_ent();
        tb_ent_t e;
        e.alu_c = $urandom;
        e.rs2   = $urandom;
        e.pc    = $urandom;
        e.rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        e.rw    = 1'($urandom_range(0, 1));
        e.mr    = 1'($urandom_range(0, 1));
        e.mw    = 1'($urandom_range(0, 1));
        e.wdsel = 2'($urandom_range(0, 2));
        e.zero  = 1'($urandom_range(0, 1));
        e.br    = 1'($urandom_range(0, 1));
        return e;
    endfunction

    task automatic model_update();
        logic o, i;
        last_in_acc = 1'b0;
        if (flush) begin
            q.delete();
        end else begin
            o = (q.size() > 0) && out_ready;
            i = in_valid && (q.size() < 2);
            last_in_acc = i;
            if (o) void'(q.pop_front());
            if (i) q.push_back(captured(cur));
            if (q.size() > 0) last = q[0];
        end
    endtask

    task automatic check_all();
        logic    v;
        tb_ent_t h;
        v = (q.size() > 0);
        h = v ? q[0] : last;
        check("out_valid",     64'(out_valid),     64'(v));
        check("in_ready",      64'(in_ready),      64'(q.size() < 2));
        check("out_alu_c",     64'(out_alu_c),     64'(h.alu_c));
        check("out_rs2",       64'(out_rs2),       64'(h.rs2));
        check("out_pc",        64'(out_pc),        64'(h.pc));
        check("out_rd",        64'(out_rd),        64'(h.rd));
        check("out_reg_write", 64'(out_reg_write), 64'(h.rw));
        check("out_mem_read",  64'(out_mem_read),  64'(h.mr));
        check("out_mem_write", 64'(out_mem_write), 64'(h.mw));
        check("out_wdsel",     64'(out_wdsel),     64'(h.wdsel));
        check("fwd_valid",     64'(fwd_valid),     64'(v && h.rw && (h.rd != 5'd0)));
        check("fwd_rd",        64'(fwd_rd),        64'(h.rd));
        check("fwd_data",      64'(fwd_data),      64'(h.alu_c));
`ifdef EXMEM_BRANCH_RESOLVE_EN
        check("branch_taken",  64'(branch_taken),  64'(v && h.br && h.zero));
        check("branch_target", 64'(branch_target), 64'({h.alu_c[31:1], 1'b0}));
`endif
    endtask

    // Inputs are driven at the negedge; this records handshakes, clocks, then checks.
    task automatic tick();
        if (out_valid && out_ready && !flush) seen.push_back(out_alu_c);
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    // Called at a negedge: pulses reset between edges and checks the reset state.
    task automatic pulse_reset();
        rstn = 1'b0;
        q.delete();
        last = '0;
        #1;
        check_all();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        #2;
        rstn = 1'b1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        for (int i = 0; i < 3; i++) tick();
    endtask

    initial begin
        tb_ent_t a, b, c, x;
        tb_ent_t exp_list[$];

        @(negedge clk);
        pulse_reset();

        // Single transfer with forwarding
        cur = '0;
        cur.alu_c = 32'h0000_1234;
        cur.rd = 5'd5;
        cur.rw = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        check("first_valid", 64'(out_valid), 64'd1);
        check("first_alu_c", 64'(out_alu_c), 64'h1234);
        check("first_fwd_v", 64'(fwd_valid), 64'd1);
        check("first_fwd_rd", 64'(fwd_rd), 64'd5);
        drain();

        // Back-pressure: A and B held, C stalled, then released in order
        a = rand_ent(); a.alu_c = 32'hA;
        b = rand_ent(); b.alu_c = 32'hB;
        c = rand_ent(); c.alu_c = 32'hC;
        seen.delete();
        out_ready = 1'b0;
        in_valid = 1'b1;
        cur = a; tick();
        cur = b; tick();
        check("stall_in_ready", 64'(in_ready), 64'd0);
        cur = c; tick();
        check("stall_head", 64'(out_alu_c), 64'hA);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (last_in_acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check("order_count", 64'(seen.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            check("order_item", 64'((i < seen.size()) ? seen[i] : 32'hDEAD), 64'(32'hA + 32'(i)));
        drain();

        // Streaming: one in, one out per cycle while holding a single entry
        exp_list.delete();
        out_ready = 1'b0;
        in_valid = 1'b1;
        cur = rand_ent();
        exp_list.push_back(cur);
        tick();
        seen.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cur = rand_ent();
            exp_list.push_back(cur);
            tick();
            check("stream_in_ready", 64'(in_ready), 64'd1);
        end
        check("stream_count", 64'(seen.size()), 64'd8);
        for (int i = 0; i < 8; i++)
            check("stream_item", 64'((i < seen.size()) ? seen[i] : 32'hDEAD), 64'(exp_list[i].alu_c));
        drain();

        // Flush while full discards everything, including the same-cycle input
        out_ready = 1'b0;
        in_valid = 1'b1;
        cur = rand_ent(); tick();
        cur = rand_ent(); tick();
        x = rand_ent();
        cur = x;
        flush = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        tick();
        check("flush_nocapture", 64'(out_valid), 64'd0);

        // Writes to x0 never request write-back or forwarding
        cur = rand_ent();
        cur.rd = 5'd0;
        cur.rw = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        check("rd0_valid", 64'(out_valid), 64'd1);
        check("rd0_reg_write", 64'(out_reg_write), 64'd0);
        check("rd0_fwd_valid", 64'(fwd_valid), 64'd0);
        drain();

`ifdef EXMEM_BRANCH_RESOLVE_EN
        cur = '0;
        cur.br = 1'b1;
        cur.zero = 1'b1;
        cur.alu_c = 32'h0000_0101;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        check("br_taken", 64'(branch_taken), 64'd1);
        check("br_target", 64'(branch_target), 64'h100);
        cur.zero = 1'b0;
        tick();
        check("br_not_taken", 64'(branch_taken), 64'd0);
        drain();
`endif

        // Random traffic with occasional flushes and one asynchronous reset
        for (int i = 0; i < 600; i++) begin
            cur = rand_ent();
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 19) == 0);
            if (i == 300) pulse_reset();
            tick();
        end
        flush = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
